out_gain: RTL and testbench
===========================

// Module: out_gain
// PURPOSE
//  Output volume stage between the delay block and the AD5660_SPI DAC driver; consumes the currently unused gain control.
//  Scales each signed audio sample by a slew-limited gain, with rounding and saturation.
//  Converts the result to offset binary, then issues one DAC go pulse per input sample.
//  mute ramps the gain to 0 without clicks; the DAC then sits at midscale.
// PARAMETERS
//  SIG_BITS   16  sample width, in and out
//  GAIN_BITS  8   gain width, unsigned Q1.(GAIN_BITS-1): 128=unity, 255=~1.99x
//  RAMP_DIV   64  accepted samples per 1-LSB gain step (>=1)
// PORTS
//  clk        in   1          system clock (clk_50 at top)
//  reset_n    in   1          asynchronous reset, active low
//  in_data    in   SIG_BITS   two's-complement sample
//  in_valid   in   1          1-cycle strobe, sample accepted; back-to-back allowed
//  gain       in   GAIN_BITS  target gain (actrls_gain)
//  mute       in   1          level; forces target gain to 0
//  out_data   out  SIG_BITS   offset-binary sample, straight to DAC .in
//  out_valid  out  1          1-cycle strobe, drives DAC .go
//  clip       out  1          high with out_valid when that sample saturated
// BEHAVIOUR
//  Reset (async, any time): out_data=2^(SIG_BITS-1) (0x8000), out_valid=0, clip=0, cur_gain=0, ramp counter=0.
//   In-flight samples are discarded.
//  Gain ramp (gain_ramp): tgt = mute ? 0 : gain. A counter increments on each in_valid.
//   On reaching RAMP_DIV-1 it wraps to 0 and cur_gain moves 1 LSB toward tgt.
//   No in_valid -> no step. cur_gain==tgt -> hold; counter keeps running.
//   Target changes mid-ramp -> steer toward the new target from the current value, never jump.
//  Sample n is multiplied by cur_gain as it stood BEFORE the step triggered by sample n.
//  Pipeline, fixed latency 3: in_valid at cycle t -> out_valid at t+3. No backpressure, no stalls, order preserved.
//   S1: register in_data and cur_gain.
//   S2: p = signed(x) * signed({1'b0,g}); width SIG_BITS+GAIN_BITS+1.
//   S3: r = (p + 2^(GAIN_BITS-2)) >>> (GAIN_BITS-1)   (round half up).
//       Saturate r to [-2^(SIG_BITS-1), 2^(SIG_BITS-1)-1]; clip=1 if limited.
//       out_data = {~r_sat[MSB], r_sat[MSB-1:0]}.
//  out_data holds its last value between strobes. clip is 0 whenever out_valid=0.
//  Muted with cur_gain==0: samples still flow, out_data=0x8000 each strobe.
//  Unity (g=128) is bit-exact: out = in ^ 0x8000.
//  Caller guarantees in_valid spacing >= DAC frame time (24 SCLK @10 MHz); not checked here.
// STRUCTURE
//  theremin_pkg:
//   - SIG_BITS/GAIN_BITS defaults and MIDSCALE constant
//   - function sat_s(): signed saturate with clip flag
//   - function to_offset_bin(): MSB invert
//  Sub-module gain_ramp (clk, reset_n, step_en, tgt, cur_gain): ramp counter and slew register.
//  out_gain holds the S1-S3 pipeline and its valid shift register.
//  Top-level hookup: in_data=delay_out, in_valid=delay_valid, gain=actrls_gain.
//   out_data/out_valid replace delay_out/delay_valid on AD5660_SPI.
// TESTING
//  1 Reset mid-burst: assert reset_n=0 on a cycle where out_valid would rise.
//    -> out_valid=0 and out_data=0x8000 same cycle, no strobe after release.
//  2 RAMP_DIV=1, gain=128 settled (128 samples); in 0x1234 -> 3 cycles later out 0x9234, clip=0.
//    in 0xEDCC -> out 0x6DCC.
//  3 gain=64 settled: in 3 -> 0x8002; in -3 -> 0x7FFF (rounding).
//    gain=255: in 0x7FFF -> 0xFFFF, clip=1; in 0x8000 -> 0x0000, clip=1.
//  4 RAMP_DIV=4, gain 0->8: cur_gain=8 after exactly 32 in_valids; 100 idle cycles without in_valid -> no change.
//  5 Settled at 128, mute=1, RAMP_DIV=1, in 0x4000 constant: cur_gain falls 1 per sample.
//    Outputs monotonically decrease toward 0x8000, hit 0x8000 at sample 128.
//    mute=0 -> ramps back up.
//  6 10 in_valid on consecutive cycles with a ramp active -> 10 consecutive out_valid, correct order.
//    Each output matches a model using the pre-step gain.

Source files
------------

// File: rtl/theremin_pkg.sv
// Shared widths, sample/product types and the saturate / offset-binary helpers
// used by the output volume stage feeding the AD5660 DAC driver.
package theremin_pkg;

  localparam int DEF_SIG_BITS  = 16;
  localparam int DEF_GAIN_BITS = 8;
  localparam int DEF_RAMP_DIV  = 64;
  localparam int PROD_BITS     = DEF_SIG_BITS + DEF_GAIN_BITS + 1;

  typedef logic signed [DEF_SIG_BITS-1:0] samp_t;
  typedef logic signed [PROD_BITS-1:0]    prod_t;

  typedef struct packed {
    logic  clip;
    samp_t val;
  } sat_t;

  localparam logic [DEF_SIG_BITS-1:0] MIDSCALE = {1'b1, {(DEF_SIG_BITS-1){1'b0}}};
  localparam prod_t SAT_MAX = prod_t'(2 ** (DEF_SIG_BITS - 1) - 1);
  localparam prod_t SAT_MIN = ~SAT_MAX;

  function automatic sat_t sat_s(input prod_t r);
    sat_t s;
    s.clip = 1'b1;
    if (r > SAT_MAX) begin
      s.val = samp_t'(SAT_MAX);
    end else if (r < SAT_MIN) begin
      s.val = samp_t'(SAT_MIN);
    end else begin
      s.val  = samp_t'(r);
      s.clip = 1'b0;
    end
    return s;
  endfunction

  // Two's complement to offset binary is just an MSB flip.
  function automatic logic [DEF_SIG_BITS-1:0] to_offset_bin(input samp_t v);
    return {~v[DEF_SIG_BITS-1], v[DEF_SIG_BITS-2:0]};
  endfunction

endpackage

// File: rtl/gain_ramp.sv
// Slew-limited gain: moves cur_gain one LSB toward tgt every RAMP_DIV accepted
// samples, so volume and mute changes never click.
module gain_ramp #(
  parameter int GAIN_BITS = 8,
  parameter int RAMP_DIV  = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 step_en,
  input  logic [GAIN_BITS-1:0] tgt,
  output logic [GAIN_BITS-1:0] cur_gain
);

  localparam int CNT_BITS = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(RAMP_DIV - 1);

  logic [CNT_BITS-1:0]  cnt;
  logic                 wrap;
  logic [GAIN_BITS-1:0] gain_nxt;

  assign wrap = (cnt == CNT_LAST);

  always_comb begin
    // NOTE: default assigned first so every path drives gain_nxt; no latch.
    gain_nxt = cur_gain;
    if (cur_gain < tgt) begin
      gain_nxt = cur_gain + 1'b1;
    end else if (cur_gain > tgt) begin
      gain_nxt = cur_gain - 1'b1;
    end
  end

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      cur_gain <= '0;
    end else if (step_en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        cur_gain <= gain_nxt;
      end
    end
  end

endmodule

// File: rtl/out_gain.sv
// Output volume stage: 3-cycle multiply / round / saturate pipeline that turns
// signed samples into offset-binary DAC words with one go strobe per sample.
module out_gain
  import theremin_pkg::*;
#(
  parameter int SIG_BITS  = DEF_SIG_BITS,
  parameter int GAIN_BITS = DEF_GAIN_BITS,
  parameter int RAMP_DIV  = DEF_RAMP_DIV
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SIG_BITS-1:0]  in_data,
  input  logic                 in_valid,
  input  logic [GAIN_BITS-1:0] gain,
  input  logic                 mute,
  output logic [SIG_BITS-1:0]  out_data,
  output logic                 out_valid,
  output logic                 clip
);

  localparam prod_t ROUND_HALF = prod_t'(2 ** (GAIN_BITS - 2));

  logic [GAIN_BITS-1:0] tgt;
  logic [GAIN_BITS-1:0] cur_gain;
  logic                 s1_valid;
  logic                 s2_valid;
  samp_t                s1_x;
  logic [GAIN_BITS-1:0] s1_g;
  prod_t                s2_p;
  prod_t                r_round;
  sat_t                 r_sat;

  assign tgt = mute ? '0 : gain;

  gain_ramp #(
    .GAIN_BITS (GAIN_BITS),
    .RAMP_DIV  (RAMP_DIV)
  ) u_gain_ramp (
    .clk      (clk),
    .reset_n  (reset_n),
    .step_en  (in_valid),
    .tgt      (tgt),
    .cur_gain (cur_gain)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= MIDSCALE;
      clip      <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      clip      <= s2_valid & r_sat.clip;
      if (s2_valid) begin
        out_data <= to_offset_bin(r_sat.val);
      end
    end
  end

  // NOTE: datapath registers carry no reset; the reset valid chain masks them.
  // s1_g captures cur_gain on the same edge that may step it, i.e. the pre-step gain.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_x <= samp_t'(in_data);
      s1_g <= cur_gain;
    end
    if (s1_valid) begin
      s2_p <= prod_t'(s1_x) * prod_t'($signed({1'b0, s1_g}));
    end
  end

  always_comb begin
    r_round = (s2_p + ROUND_HALF) >>> (GAIN_BITS - 1);
    r_sat   = sat_s(r_round);
  end

endmodule

// File: tb/tb_out_gain.sv
// Bench for out_gain: two instances (RAMP_DIV 1 and 4) share stimulus; a
// reference model pushes expected words to per-instance queues.
module tb_out_gain;

  typedef struct packed {
    logic        clip;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk_50   = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  gain     = '0;
  logic        mute     = 1'b0;
  logic [7:0]  gain_set = '0;
  logic        mute_set = 1'b0;

  logic [15:0] od1, od4;
  logic        ov1, ov4, cl1, cl4;

  exp_t q1[$];
  exp_t q4[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   strobes1 = 0;
  int   strobes4 = 0;
  int   mg1      = 0;
  int   mg4      = 0;
  int   mc4      = 0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc++;

  out_gain #(.RAMP_DIV(1)) dut1 (
    .clk(clk_50), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .gain(gain), .mute(mute), .out_data(od1), .out_valid(ov1), .clip(cl1)
  );

  out_gain #(.RAMP_DIV(4)) dut4 (
    .clk(clk_50), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .gain(gain), .mute(mute), .out_data(od4), .out_valid(ov4), .clip(cl4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic exp_t model_out(input logic [15:0] x, input int g);
    longint p, r;
    exp_t   e;
    p = longint'($signed(x)) * longint'(g);
    r = (p + 64) >>> 7;
    e.clip = 1'b0;
    if (r > 32767) begin
      r = 32767;
      e.clip = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.clip = 1'b1;
    end
    e.data = 16'(r) ^ 16'h8000;
    e.cyc  = cyc + 3;
    return e;
  endfunction

  function automatic int step_gain(input int g, input int tgt);
    if (g < tgt) return g + 1;
    if (g > tgt) return g - 1;
    return g;
  endfunction

  // Drive one sample; optional fixed expectations override the model per instance.
  task automatic send(input logic [15:0] x,
                      input bit k1 = 1'b0, input logic [16:0] c1 = '0,
                      input bit k4 = 1'b0, input logic [16:0] c4 = '0);
    exp_t e1, e4;
    int   tgt;
    @(negedge clk_50);
    gain     = gain_set;
    mute     = mute_set;
    in_data  = x;
    in_valid = 1'b1;
    tgt = mute ? 0 : int'(gain);
    e1 = model_out(x, mg1);
    e4 = model_out(x, mg4);
    if (k1) begin
      e1.clip = c1[16];
      e1.data = c1[15:0];
    end
    if (k4) begin
      e4.clip = c4[16];
      e4.data = c4[15:0];
    end
    q1.push_back(e1);
    q4.push_back(e4);
    mg1 = step_gain(mg1, tgt);
    if (mc4 == 3) begin
      mc4 = 0;
      mg4 = step_gain(mg4, tgt);
    end else begin
      mc4++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_50);
      in_valid = 1'b0;
      gain     = gain_set;
      mute     = mute_set;
    end
  endtask

  always @(negedge clk_50) begin
    exp_t e;
    if (ov1) begin
      strobes1++;
      check("dut1_queue_nonempty", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut1_data", od1, e.data);
        check("dut1_clip", cl1, e.clip);
        check("dut1_latency", cyc, e.cyc);
      end
    end else begin
      check("dut1_clip_idle", cl1, 0);
    end
  end

  always @(negedge clk_50) begin
    exp_t e;
    if (ov4) begin
      strobes4++;
      check("dut4_queue_nonempty", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("dut4_data", od4, e.data);
        check("dut4_clip", cl4, e.clip);
        check("dut4_latency", cyc, e.cyc);
      end
    end else begin
      check("dut4_clip_idle", cl4, 0);
    end
  end

  initial begin
    repeat (3) @(negedge clk_50);
    check("reset_data1", od1, 16'h8000);
    check("reset_valid1", ov1, 0);
    check("reset_data4", od4, 16'h8000);
    check("reset_valid4", ov4, 0);
    reset_n = 1'b1;
    idle(2);

    // Unity gain is bit-exact.
    gain_set = 8'd128;
    repeat (128) send(16'h4000);
    send(16'h1234, 1'b1, {1'b0, 16'h9234});
    send(16'hEDCC, 1'b1, {1'b0, 16'h6DCC});
    idle(4);

    // Rounding at half gain, then saturation at max gain.
    gain_set = 8'd64;
    repeat (64) send(16'h4000);
    send(16'h0003, 1'b1, {1'b0, 16'h8002});
    send(16'hFFFD, 1'b1, {1'b0, 16'h7FFF});
    gain_set = 8'd255;
    repeat (191) send(16'h4000);
    send(16'h7FFF, 1'b1, {1'b1, 16'hFFFF});
    send(16'h8000, 1'b1, {1'b1, 16'h0000});
    idle(4);

    // Reset lands on the cycle the first burst sample strobes out.
    send(16'h1000);
    send(16'h2000);
    send(16'h3000);
    @(posedge clk_50);
    #1;
    check("strobe_before_reset", ov1, 1);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    q1.delete();
    q4.delete();
    mg1 = 0;
    mg4 = 0;
    mc4 = 0;
    #1;
    check("reset_mid_valid1", ov1, 0);
    check("reset_mid_data1", od1, 16'h8000);
    check("reset_mid_valid4", ov4, 0);
    check("reset_mid_data4", od4, 16'h8000);
    @(negedge clk_50);
    strobes1 = 0;
    strobes4 = 0;
    reset_n  = 1'b1;
    idle(10);
    check("no_strobe_after_reset1", strobes1, 0);
    check("no_strobe_after_reset4", strobes4, 0);

    // RAMP_DIV=4: gain reaches 8 after exactly 32 samples, holds while idle.
    gain_set = 8'd8;
    for (int i = 0; i < 31; i++) send(16'h4000);
    send(16'h4000, 1'b0, '0, 1'b1, {1'b0, 16'h8380});
    send(16'h4000, 1'b0, '0, 1'b1, {1'b0, 16'h8400});
    idle(100);
    send(16'h4000, 1'b0, '0, 1'b1, {1'b0, 16'h8400});
    idle(4);

    // Mute ramps down one step per sample to midscale, then unmute ramps up.
    gain_set = 8'd128;
    repeat (120) send(16'h4000);
    mute_set = 1'b1;
    send(16'h4000, 1'b1, {1'b0, 16'hC000});
    for (int i = 1; i < 130; i++) begin
      if (i == 128) send(16'h4000, 1'b1, {1'b0, 16'h8000});
      else send(16'h4000);
    end
    mute_set = 1'b0;
    repeat (10) send(16'h4000);
    idle(4);

    // Back-to-back burst while the ramp is moving.
    strobes1 = 0;
    strobes4 = 0;
    for (int i = 0; i < 10; i++) send(16'(i * 3001 - 15000));
    idle(6);
    check("burst_strobes1", strobes1, 10);
    check("burst_strobes4", strobes4, 10);

    for (int i = 0; i < 20 && (q1.size() + q4.size()) != 0; i++) @(negedge clk_50);
    check("queues_drained", 32'(q1.size() + q4.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
